// File: rtl/mem_req_master_if.sv
// rtl/mem_req_master_if.sv - data-memory request/acknowledge bus
// Master drives a held word-aligned request; slave returns one mack per request.
interface mem_req_master_if #(
  parameter int ADDR_W = 32
);
  logic              mreq;
  logic              mwe;
  logic [ADDR_W-1:0] maddr;
  logic [31:0]       mwdata;
  logic [3:0]        mbe;
  logic [31:0]       mrdata;
  logic              mack;

  modport master (
    output mreq, mwe, maddr, mwdata, mbe,
    input  mrdata, mack
  );

  modport slave (
    input  mreq, mwe, maddr, mwdata, mbe,
    output mrdata, mack
  );
endinterface

// File: rtl/mem_req_master.sv
// rtl/mem_req_master.sv - MEM-stage load/store initiator with pipeline freeze
// One access per instruction; misaligned, conflicting and timed-out accesses pulse err.
module mem_req_master #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_r_en_in,
  input  logic              mem_w_en_in,
  input  logic              size_in,
  input  logic              sign_in,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [31:0]       st_val,
  output logic              freeze,
  output logic [31:0]       load_value,
  output logic              load_valid,
  output logic              err,
  mem_req_master_if.master  mem
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] TO = 8'(TIMEOUT);

  state_t            r_state;
  logic              r_mreq;
  logic              r_mwe;
  logic [ADDR_W-1:0] r_maddr;
  logic [3:0]        r_mbe;
  logic [31:0]       r_mwdata;
  logic              r_size;
  logic              r_sign;
  logic [1:0]        r_lane;
  logic [7:0]        r_cnt;
  logic [31:0]       r_load_value;
  logic              r_load_valid;
  logic              r_err;

  state_t            w_state_nxt;
  logic              w_mreq_nxt;
  logic              w_mwe_nxt;
  logic [ADDR_W-1:0] w_maddr_nxt;
  logic [3:0]        w_mbe_nxt;
  logic [31:0]       w_mwdata_nxt;
  logic              w_size_nxt;
  logic              w_sign_nxt;
  logic [1:0]        w_lane_nxt;
  logic [7:0]        w_cnt_nxt;
  logic [31:0]       w_load_value_nxt;
  logic              w_load_valid_nxt;
  logic              w_err_nxt;
  logic              w_freeze;
  logic              w_access;
  logic              w_bad;
  logic [7:0]        w_byte;
  logic [31:0]       w_rd_ext;

  assign w_access = mem_r_en_in | mem_w_en_in;
  assign w_bad    = (mem_r_en_in & mem_w_en_in) | (~size_in & (addr_in[1:0] != 2'b00));

  always_comb begin
    w_byte = mem.mrdata[7:0];
    unique case (r_lane)
      2'd0: w_byte = mem.mrdata[7:0];
      2'd1: w_byte = mem.mrdata[15:8];
      2'd2: w_byte = mem.mrdata[23:16];
      2'd3: w_byte = mem.mrdata[31:24];
    endcase
    w_rd_ext = r_size ? {{24{r_sign & w_byte[7]}}, w_byte} : mem.mrdata;
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_mreq_nxt       = r_mreq;
    w_mwe_nxt        = r_mwe;
    w_maddr_nxt      = r_maddr;
    w_mbe_nxt        = r_mbe;
    w_mwdata_nxt     = r_mwdata;
    w_size_nxt       = r_size;
    w_sign_nxt       = r_sign;
    w_lane_nxt       = r_lane;
    w_cnt_nxt        = r_cnt;
    w_load_value_nxt = r_load_value;
    w_load_valid_nxt = 1'b0;
    w_err_nxt        = 1'b0;
    w_freeze         = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (w_access) begin
          w_freeze = 1'b1;
          if (w_bad) begin
            w_state_nxt = DONE;
            w_err_nxt   = 1'b1;
          end else begin
            w_state_nxt  = REQ;
            w_mreq_nxt   = 1'b1;
            w_mwe_nxt    = mem_w_en_in;
            w_maddr_nxt  = {addr_in[ADDR_W-1:2], 2'b00};
            w_mbe_nxt    = size_in ? (4'b0001 << addr_in[1:0]) : 4'hF;
            w_mwdata_nxt = size_in ? {4{st_val[7:0]}} : st_val;
            w_size_nxt   = size_in;
            w_sign_nxt   = sign_in;
            w_lane_nxt   = addr_in[1:0];
            w_cnt_nxt    = 8'd0;
          end
        end
      end
      REQ: begin
        w_freeze = 1'b1;
        if (mem.mack) begin
          w_mreq_nxt  = 1'b0;
          w_state_nxt = DONE;
          if (!r_mwe) begin
            w_load_value_nxt = w_rd_ext;
            w_load_valid_nxt = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
          // A late mack arriving with the final count still wins over the abort.
          if (r_cnt + 8'd1 == TO) begin
            w_mreq_nxt  = 1'b0;
            w_state_nxt = DONE;
            w_err_nxt   = 1'b1;
          end
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
        w_mreq_nxt  = 1'b0;
      end
    endcase

    if (rst) begin
      w_freeze = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_mreq       <= 1'b0;
      r_mwe        <= 1'b0;
      r_maddr      <= '0;
      r_mbe        <= 4'h0;
      r_mwdata     <= 32'h0;
      r_size       <= 1'b0;
      r_sign       <= 1'b0;
      r_lane       <= 2'b00;
      r_cnt        <= 8'd0;
      r_load_value <= 32'h0;
      r_load_valid <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_mreq       <= w_mreq_nxt;
      r_mwe        <= w_mwe_nxt;
      r_maddr      <= w_maddr_nxt;
      r_mbe        <= w_mbe_nxt;
      r_mwdata     <= w_mwdata_nxt;
      r_size       <= w_size_nxt;
      r_sign       <= w_sign_nxt;
      r_lane       <= w_lane_nxt;
      r_cnt        <= w_cnt_nxt;
      r_load_value <= w_load_value_nxt;
      r_load_valid <= w_load_valid_nxt;
      r_err        <= w_err_nxt;
    end
  end

  assign freeze     = w_freeze;
  assign load_value = r_load_value;
  assign load_valid = r_load_valid;
  assign err        = r_err;
  assign mem.mreq   = r_mreq;
  assign mem.mwe    = r_mwe;
  assign mem.maddr  = r_maddr;
  assign mem.mbe    = r_mbe;
  assign mem.mwdata = r_mwdata;

endmodule

// File: tb/tb_mem_req_master.sv
// tb/tb_mem_req_master.sv - vector table and scoreboard bench for mem_req_master
// Memory responder acks after a per-vector wait count; DUT runs with TIMEOUT=4.
module tb_mem_req_master;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_r_en_in = 1'b0;
  logic        mem_w_en_in = 1'b0;
  logic        size_in = 1'b0;
  logic        sign_in = 1'b0;
  logic [31:0] addr_in = 32'h0;
  logic [31:0] st_val = 32'h0;
  logic        freeze;
  logic [31:0] load_value;
  logic        load_valid;
  logic        err;

  mem_req_master_if #(.ADDR_W(32)) mbus ();

  mem_req_master #(.ADDR_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
    .size_in(size_in), .sign_in(sign_in), .addr_in(addr_in), .st_val(st_val),
    .freeze(freeze), .load_value(load_value), .load_valid(load_valid), .err(err),
    .mem(mbus.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd, wr, size, sign;
    logic [31:0] addr, st, rdata;
    int          waits;
    int          exp_mreq;
    logic        exp_mwe;
    logic [31:0] exp_maddr;
    logic [3:0]  exp_mbe;
    logic        chk_wd;
    logic [31:0] exp_wd;
    int          exp_fz;
    logic        exp_lv, exp_err;
    logic [31:0] exp_val;
  } vec_t;

  vec_t vecs[12];
  vec_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int   fz, mq;
    logic done;
    logic got_lv, got_err;
    logic [31:0] got_val;
    vec_t e;
    fz = 0; mq = 0; done = 1'b0;
    got_lv = 1'b0; got_err = 1'b0; got_val = 32'h0;
    @(negedge clk);
    mem_r_en_in = v.rd; mem_w_en_in = v.wr; size_in = v.size; sign_in = v.sign;
    addr_in = v.addr; st_val = v.st; mbus.mrdata = v.rdata; mbus.mack = 1'b0;
    exp_q.push_back(v);
    for (int c = 0; c < 40 && !done; c++) begin
      if (c > 0) @(negedge clk);
      mbus.mack = 1'b0;
      #1;
      if (freeze) fz++;
      if (mbus.mreq) begin
        if (mq == 0) begin
          chk($sformatf("v%0d mwe", idx), 32'(mbus.mwe), 32'(v.exp_mwe));
          chk($sformatf("v%0d maddr", idx), mbus.maddr, v.exp_maddr);
          chk($sformatf("v%0d mbe", idx), 32'(mbus.mbe), 32'(v.exp_mbe));
          if (v.chk_wd) chk($sformatf("v%0d mwdata", idx), mbus.mwdata, v.exp_wd);
        end
        if (mq == v.waits) mbus.mack = 1'b1;
        mq++;
      end
      if (c > 0 && !freeze) begin
        done = 1'b1;
        got_lv = load_valid; got_err = err; got_val = load_value;
      end
    end
    if (!done) begin
      n_tests++; n_fail++;
      $display("FAIL v%0d done_timeout: got no DONE expected DONE within 40 cycles", idx);
    end
    if (exp_q.size() == 0) begin
      n_tests++; n_fail++;
      $display("FAIL v%0d scoreboard: got empty queue expected entry", idx);
    end else begin
      e = exp_q.pop_front();
      chk($sformatf("v%0d mreq_cycles", idx), 32'(mq), 32'(e.exp_mreq));
      chk($sformatf("v%0d freeze_cycles", idx), 32'(fz), 32'(e.exp_fz));
      chk($sformatf("v%0d load_valid", idx), 32'(got_lv), 32'(e.exp_lv));
      chk($sformatf("v%0d err", idx), 32'(got_err), 32'(e.exp_err));
      chk($sformatf("v%0d load_value", idx), got_val, e.exp_val);
    end
    @(negedge clk);
    mem_r_en_in = 1'b0; mem_w_en_in = 1'b0; mbus.mack = 1'b0;
    #1;
    chk($sformatf("v%0d pulse_end", idx), {29'h0, load_valid, err, freeze}, 32'h0);
  endtask

  initial begin
    vec_t post;
    mbus.mack = 1'b0;
    mbus.mrdata = 32'h0;
    //       rd wr sz sg addr   st            rdata         w    mq mwe maddr  mbe  cwd wd            fz lv er val
    vecs[0]  = '{0, 1, 0, 0, 32'h10, 32'h1234_5678, 32'h0,        0,   1, 1, 32'h10, 4'hF, 1, 32'h1234_5678, 2, 0, 0, 32'h0};
    vecs[1]  = '{1, 0, 0, 0, 32'h20, 32'h0,         32'hCAFE_F00D, 3,  4, 0, 32'h20, 4'hF, 0, 32'h0,         5, 1, 0, 32'hCAFE_F00D};
    vecs[2]  = '{1, 0, 1, 1, 32'h13, 32'h0,         32'h80FF_0000, 0,  1, 0, 32'h10, 4'h8, 0, 32'h0,         2, 1, 0, 32'hFFFF_FF80};
    vecs[3]  = '{1, 0, 1, 0, 32'h13, 32'h0,         32'h80FF_0000, 1,  2, 0, 32'h10, 4'h8, 0, 32'h0,         3, 1, 0, 32'h0000_0080};
    vecs[4]  = '{0, 1, 1, 0, 32'h22, 32'h0000_00A5, 32'h0,        0,   1, 1, 32'h20, 4'h4, 1, 32'hA5A5_A5A5, 2, 0, 0, 32'h0000_0080};
    vecs[5]  = '{1, 0, 0, 0, 32'h06, 32'h0,         32'h0,        0,   0, 0, 32'h0,  4'h0, 0, 32'h0,         1, 0, 1, 32'h0000_0080};
    vecs[6]  = '{1, 1, 0, 0, 32'h40, 32'h0,         32'h0,        0,   0, 0, 32'h0,  4'h0, 0, 32'h0,         1, 0, 1, 32'h0000_0080};
    vecs[7]  = '{1, 0, 0, 0, 32'h30, 32'h0,         32'hDEAD_BEEF, 255, 4, 0, 32'h30, 4'hF, 0, 32'h0,        5, 0, 1, 32'h0000_0080};
    vecs[8]  = '{1, 0, 1, 1, 32'h01, 32'h0,         32'h0000_7F00, 2,  3, 0, 32'h0,  4'h2, 0, 32'h0,         4, 1, 0, 32'h0000_007F};
    vecs[9]  = '{1, 0, 1, 1, 32'h02, 32'h0,         32'h00AB_0000, 0,  1, 0, 32'h0,  4'h4, 0, 32'h0,         2, 1, 0, 32'hFFFF_FFAB};
    vecs[10] = '{0, 1, 1, 0, 32'h03, 32'hFFFF_FF5A, 32'h0,        1,   2, 1, 32'h0,  4'h8, 1, 32'h5A5A_5A5A, 3, 0, 0, 32'hFFFF_FFAB};
    vecs[11] = '{0, 1, 0, 0, 32'h11, 32'h0,         32'h0,        0,   0, 0, 32'h0,  4'h0, 0, 32'h0,         1, 0, 1, 32'hFFFF_FFAB};
    post     = '{1, 0, 0, 0, 32'h44, 32'h0,         32'h1122_3344, 0,  1, 0, 32'h44, 4'hF, 0, 32'h0,         2, 1, 0, 32'h1122_3344};

    mem_r_en_in = 1'b1;
    #2;
    chk("rst freeze", 32'(freeze), 32'h0);
    chk("rst mreq", 32'(mbus.mreq), 32'h0);
    chk("rst pulses", {30'h0, load_valid, err}, 32'h0);
    chk("rst load_value", load_value, 32'h0);
    chk("rst mbe", 32'(mbus.mbe), 32'h0);
    mem_r_en_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    mbus.mrdata = 32'h5555_5555;
    mbus.mack = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("stray mack load_valid", 32'(load_valid), 32'h0);
    chk("stray mack load_value", load_value, 32'h0);
    chk("stray mack freeze", 32'(freeze), 32'h0);
    mbus.mack = 1'b0;

    for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

    @(negedge clk);
    mem_r_en_in = 1'b1; addr_in = 32'h50; size_in = 1'b0;
    @(negedge clk);
    #1;
    chk("midreq mreq_up", 32'(mbus.mreq), 32'h1);
    rst = 1'b1;
    #1;
    chk("midreq mreq_drop", 32'(mbus.mreq), 32'h0);
    chk("midreq freeze_drop", 32'(freeze), 32'h0);
    chk("midreq load_value", load_value, 32'h0);
    mem_r_en_in = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    run_vec(post, 12);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
